// File: rtl/arith_arbiter_if.sv
// Handshake bundle between two requesters, the shared add/sub arbiter and the result consumer.
// res_ovf exists only when ARITH_ARB_OVF_EN is defined.
interface arith_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ctrl;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ctrl;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_z;
    logic             res_cout;
    logic             res_id;
`ifdef ARITH_ARB_OVF_EN
    logic             res_ovf;
`endif

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_z, res_cout, res_id
`ifdef ARITH_ARB_OVF_EN
        , input res_ovf
`endif
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_z, res_cout, res_id
`ifdef ARITH_ARB_OVF_EN
        , output res_ovf
`endif
    );
endinterface

// File: rtl/arith_arbiter.sv
// Two-requester round-robin arbiter sharing one add/sub unit with a single result register.
// Define ARITH_ARB_OVF_EN to add the registered signed-overflow flag res_ovf.
module arith_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    arith_arbiter_if.slave     bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t           state, state_next;
    logic             last_grant;
    logic             grant;
    logic             slot_free;
    logic             accept;
    logic             op_ctrl;
    logic [WIDTH-1:0] op_a, op_b, b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] z_reg;
    logic             cout_reg;
    logic             id_reg;
`ifdef ARITH_ARB_OVF_EN
    logic             ovf_reg;
`endif

    // Reset gates the slot so nothing is accepted while it is asserted.
    assign slot_free = !reset && ((state == IDLE) || bus.res_ready);

    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        grant = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid)
            grant = ~last_grant;
    end

    assign bus.req0_ready = slot_free && bus.req0_valid && !grant;
    assign bus.req1_ready = slot_free && bus.req1_valid && grant;
    assign accept         = bus.req0_ready || bus.req1_ready;

    assign op_a    = grant ? bus.req1_a    : bus.req0_a;
    assign op_b    = grant ? bus.req1_b    : bus.req0_b;
    assign op_ctrl = grant ? bus.req1_ctrl : bus.req0_ctrl;
    assign b_eff   = op_ctrl ? ~op_b : op_b;
    assign sum     = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_ctrl};

    always_comb begin
        state_next = state;
        if (accept)
            state_next = HOLD;
        else if (state == HOLD && bus.res_ready)
            state_next = IDLE;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            z_reg      <= '0;
            cout_reg   <= 1'b0;
            id_reg     <= 1'b0;
`ifdef ARITH_ARB_OVF_EN
            ovf_reg    <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                last_grant <= grant;
                z_reg      <= sum[WIDTH-1:0];
                cout_reg   <= sum[WIDTH];
                id_reg     <= grant;
`ifdef ARITH_ARB_OVF_EN
                ovf_reg    <= (op_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                              (sum[WIDTH-1] != op_a[WIDTH-1]);
`endif
            end
        end
    end

    assign bus.res_valid = (state == HOLD);
    assign bus.res_z     = z_reg;
    assign bus.res_cout  = cout_reg;
    assign bus.res_id    = id_reg;
`ifdef ARITH_ARB_OVF_EN
    assign bus.res_ovf   = ovf_reg;
`endif
endmodule

// File: doc/arith_arbiter.md
ARITH_ARBITER -- requirements
Module: arith_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req0_valid  input  1  requester 0 has an operation pending.
REQ-005 Port: req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 Port: req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-007 Port: req0_ctrl  input  1  requester 0 op select: 0 add, 1 subtract.
REQ-008 Ports req1_valid, req1_ready, req1_a, req1_b and req1_ctrl SHALL mirror REQ-004..REQ-007 for requester 1.
REQ-009 Port: res_valid  output  1  result register holds an unconsumed result.
REQ-010 Port: res_ready  input  1  consumer accepts the result this cycle.
REQ-011 Port: res_z  output  WIDTH  registered result.
REQ-012 Port: res_cout  output  1  registered carry-out.
REQ-013 Port: res_id  output  1  index of the requester that produced res_z.
REQ-014 Port: res_ovf  output  1  registered signed overflow; present only with ARITH_ARB_OVF_EN.

Function
REQ-015 The single shared add/sub unit SHALL compute z = a + (ctrl ? ~b : b) + ctrl, modulo 2^WIDTH; cout SHALL be bit WIDTH of the (WIDTH+1)-bit sum.
REQ-016 FSM states SHALL be IDLE (res_valid=0) and HOLD (res_valid=1).
REQ-017 The arbiter SHALL be able to accept (slot_free) when state is IDLE, or when state is HOLD and res_ready=1.
REQ-018 Grant: with one valid, grant that requester; with both valid, grant the requester not in last_grant.
REQ-019 reqN_ready SHALL be asserted combinationally iff slot_free=1 and requester N is granted; at most one ready SHALL be high per cycle.
REQ-020 An accepted operation (valid and ready both high) SHALL load res_z, res_cout, res_id (and res_ovf) on the next edge, set state to HOLD and update last_grant to the granted requester; latency is 1 cycle.
REQ-021 In HOLD with res_ready=1 and no accepted request, state SHALL return to IDLE; with an accepted request it SHALL stay in HOLD with new contents, giving one result per cycle.
REQ-022 In HOLD with res_ready=0, res_z, res_cout, res_id and res_ovf SHALL hold stable, and both readies SHALL be 0.
REQ-023 last_grant SHALL change only on acceptance; a requester dropping valid SHALL not alter it.
REQ-024 res_ready asserted in IDLE SHALL have no effect.

Reset
REQ-025 Reset SHALL have priority over every other input on the active edge.
REQ-026 Reset SHALL set state=IDLE, res_valid=0, res_z=0, res_cout=0, res_id=0, res_ovf=0, and last_grant=1 so that requester 0 wins the first contention.
REQ-027 Reset asserted in HOLD SHALL discard the held result with no handshake; no request SHALL be accepted while reset=1 (both readies 0).

Configuration
REQ-028 With macro ARITH_ARB_OVF_EN defined, res_ovf SHALL exist and be registered as (a[WIDTH-1] == b_eff[WIDTH-1]) && (z[WIDTH-1] != a[WIDTH-1]), where b_eff = ctrl ? ~b : b.
REQ-029 Without ARITH_ARB_OVF_EN, the res_ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Reset for 2 cycles, all valids at 0 -> res_valid=0, res_z=0, req0_ready=req1_ready=0.
REQ-031 req0 a=5, b=3, ctrl=0, one cycle -> req0_ready=1 that cycle; next cycle res_valid=1, res_z=8, res_cout=0, res_id=0.
REQ-032 req1 a=5, b=3, ctrl=1 -> res_z=2, res_cout=1, res_id=1.
REQ-033 Both valid continuously, res_ready=1 after reset -> res_id sequence 0,1,0,1 on consecutive cycles, res_valid high every cycle.
REQ-034 res_ready=0 for 3 cycles in HOLD with both valid -> res_z stable and both readies 0; res_ready=1 and reset=1 in the same cycle -> IDLE with res_valid=0 next cycle.
REQ-035 With ARITH_ARB_OVF_EN: a=0x7FFFFFFF, b=1, ctrl=0 -> res_z=0x80000000, res_ovf=1; a=0x80000000, b=1, ctrl=1 -> res_z=0x7FFFFFFF, res_ovf=1.
